shift_unit: RTL
===============

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001: Parameter WIDTH, default 16, datapath width in bits; legal values are powers of two, minimum 4.
REQ-002: Parameter AMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003: Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004: Port reset, input, 1, asynchronous active-high reset.
REQ-005: Port in_valid, input, 1, request holds valid in_data/in_mode/in_amt.
REQ-006: Port in_ready, output, 1, unit can accept a request.
REQ-007: Port in_data, input, WIDTH, operand.
REQ-008: Port in_mode, input, 2, 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009: Port in_amt, input, AMT_W, shift distance, 0..WIDTH-1.
REQ-010: Port out_valid, output, 1, result available.
REQ-011: Port out_ready, input, 1, consumer takes the result.
REQ-012: Port out_data, output, WIDTH, shifted result.
REQ-013: Port out_carry, output, 1, last bit shifted or rotated out; 0 when amt = 0.
REQ-014: Port out_zero, output, 1, out_data == 0.

Function
REQ-015: FSM states: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016: Accept occurs at an edge where in_valid && in_ready; at that edge, in_data is loaded into the working register and in_mode/in_amt are captured into internal registers.
REQ-017: At accept, if in_amt == 0: go to DONE, carry = 0; otherwise go to SHIFT with count = in_amt.
REQ-018: Each edge in SHIFT performs exactly one 1-bit step of the captured mode and decrements count; the edge where count == 1 moves to DONE.
REQ-019: 1-bit step semantics: LSL shift left, fill 0, carry = old MSB; LSR shift right, fill 0, carry = old LSB; ASR shift right, fill old MSB, carry = old LSB; ROR rotate right, new MSB = old LSB, carry = old LSB.
REQ-020: Latency: with accept at edge k, out_valid is first high after edge k+amt, so k+0 for amt = 0.
REQ-021: out_data, out_carry and out_zero are registered, and they hold stable while out_valid = 1.
REQ-022: In DONE, at an edge with out_ready = 1: go to IDLE; out_valid deasserts; out_data, out_carry and out_zero keep the last result.
REQ-023: DONE with out_ready = 0 holds indefinitely.
REQ-024: There is no same-edge DONE->accept bypass; the minimum request spacing is amt+2 cycles.
REQ-025: in_valid, in_data, in_mode and in_amt are ignored outside IDLE; changes to them during SHIFT or DONE do not affect the result.
REQ-026: out_ready is ignored outside DONE.
REQ-027: in_amt values of WIDTH or more cannot occur at the AMT_W width; no saturation logic is required.
REQ-028: Equivalence: for every mode and amt, the result equals the combinational shift of in_data by amt, with ASR sign-preserving and ROR modulo WIDTH.

Reset
REQ-029: On reset assertion, the unit immediately enters IDLE, independent of clk.
REQ-030: On reset assertion, out_valid = 0, out_data = 0, out_carry = 0, out_zero = 1, count = 0 and in_ready = 1.
REQ-031: A reset asserted during SHIFT or DONE discards the request; no out_valid is produced for it.
REQ-032: After reset deassertion, the first accept is possible at the next rising edge.

Verification (WIDTH = 16)
REQ-033: Test LSL: 0x0001, amt 4 -> out_data 0x0010, carry 0, zero 0, out_valid after edge k+4.
REQ-034: Test ASR: 0x8000, amt 3 -> 0xF000, carry 0; ASR 0x8001, amt 1 -> 0xC000, carry 1.
REQ-035: Test ROR: 0x0001, amt 1 -> 0x8000, carry 1; LSR 0xFFFF, amt 15 -> 0x0001, carry 1, valid after edge k+15.
REQ-036: Test amt 0: LSR 0x1234 -> 0x1234, carry 0, out_valid after edge k; hold out_ready = 0 for 5 cycles with outputs stable and in_ready = 0; toggle in_data with no effect; out_ready = 1 returns to IDLE next edge.
REQ-037: Test LSL by 1: 0x8000 -> 0x0000, carry 1, zero 1.
REQ-038: Test reset mid-SHIFT: reset during LSL 0x00FF, amt 8, after 3 shift edges -> immediately out_valid 0, out_data 0x0000, in_ready 1; a new request then completes correctly.

Source files
------------

// File: rtl/shift_unit.sv
// shift_unit: iterative barrel-less shifter. It performs one 1-bit step per
// clock in the captured mode (LSL, LSR, ASR, ROR), so the latency equals the
// shift amount.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - request handshake (in_data, in_mode, in_amt)
//   out_valid/out_ready - result handshake (out_data, out_carry, out_zero)
//   state_dbg           - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable until that edge. in_ready is
// high only in IDLE and out_valid is high only in DONE, so a new request can
// never be accepted on the same edge that a result is consumed.
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       mode_q, mode_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  // One 1-bit step of the captured mode applied to the working register.
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  always_comb begin
    step_data  = work_q;
    step_carry = 1'b0;
    case (mode_q)
      MODE_LSL: begin
        step_data  = {work_q[WIDTH-2:0], 1'b0};
        step_carry = work_q[WIDTH-1];
      end
      MODE_LSR: begin
        step_data  = {1'b0, work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      MODE_ASR: begin
        step_data  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      default: begin // ROR
        step_data  = {work_q[0], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    count_d = count_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          mode_d = in_mode;
          if (in_amt == '0) begin
            // Zero-distance request: the result is the operand itself.
            res_d   = in_data;
            carry_d = 1'b0;
            zero_d  = (in_data == '0);
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = in_amt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = step_data;
        count_d = count_q - 1'b1;
        // The final step publishes straight into the result registers, so
        // the outputs only change when a result becomes valid.
        if (count_q == AMT_W'(1)) begin
          res_d   = step_data;
          carry_d = step_carry;
          zero_d  = (step_data == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= '0;
      count_q <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;
  assign state_dbg = state_q;

endmodule
